// File: rtl/alu_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_arb_pkg: shared opcode/slot-state types and data width for the   |
// | ALU arbiter.                                                         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package alu_arb_pkg;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_e;
endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_core: combinational add/sub/and/or; carry output present only    |
// | when ALU_ARB_FLAGS_EN is defined.                                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_core
  import alu_arb_pkg::*;
(
  input  op_e               op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] out
`ifdef ALU_ARB_FLAGS_EN
  ,
  output logic              carry
`endif
);

  // Bit DATA_W is carry-out for add and borrow (a < b) for sub.
  logic [DATA_W:0] wide;

  always_comb begin
    wide = '0;
    case (op)
      OP_ADD:  wide = {1'b0, a} + {1'b0, b};
      OP_SUB:  wide = {1'b0, a} - {1'b0, b};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      default: wide = '0;
    endcase
  end

  assign out = wide[DATA_W-1:0];

`ifdef ALU_ARB_FLAGS_EN
  assign carry = wide[DATA_W];
`else
  logic unused_carry;
  assign unused_carry = wide[DATA_W];
`endif

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_arbiter: two-requester ALU front end with a one-entry result     |
// | slot; ALU_ARB_FLAGS_EN adds registered carry/zero flags.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [1:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [1:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_id
`ifdef ALU_ARB_FLAGS_EN
  ,
  output logic              rsp_carry,
  output logic              rsp_zero
`endif
);

  slot_e             state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              id_q, id_d;
  logic              last_q, last_d;
`ifdef ALU_ARB_FLAGS_EN
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic              alu_carry;
`endif

  logic              slot_free;
  logic              grant;
  logic              sel;
  op_e               alu_op;
  logic [DATA_W-1:0] alu_a, alu_b, alu_out;

  // Gating with rst keeps a handshake from completing while reset is held.
  assign slot_free = (state_q == EMPTY) || rsp_ready;
  assign grant     = slot_free && (req0_valid || req1_valid) && !rst;

  generate
    if (FIXED_PRIO != 0) begin : g_fixed_prio
      assign sel = !req0_valid;
    end else begin : g_round_robin
      assign sel = (req0_valid && req1_valid) ? !last_q : req1_valid;
    end
  endgenerate

  assign req0_ready = grant && !sel;
  assign req1_ready = grant && sel;

  assign alu_op = op_e'(sel ? req1_op : req0_op);
  assign alu_a  = sel ? req1_a : req0_a;
  assign alu_b  = sel ? req1_b : req0_b;

  alu_core u_alu (
    .op    (alu_op),
    .a     (alu_a),
    .b     (alu_b),
    .out   (alu_out)
`ifdef ALU_ARB_FLAGS_EN
    ,
    .carry (alu_carry)
`endif
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    last_d  = last_q;
`ifdef ALU_ARB_FLAGS_EN
    carry_d = carry_q;
    zero_d  = zero_q;
`endif
    if (grant) begin
      state_d = FULL;
      data_d  = alu_out;
      id_d    = sel;
      last_d  = sel;
`ifdef ALU_ARB_FLAGS_EN
      carry_d = alu_carry;
      zero_d  = (alu_out == '0);
`endif
    end else if ((state_q == FULL) && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
`ifdef ALU_ARB_FLAGS_EN
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      last_q  <= last_d;
`ifdef ALU_ARB_FLAGS_EN
      carry_q <= carry_d;
      zero_q  <= zero_d;
`endif
    end
  end

  assign rsp_valid = (state_q == FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
`ifdef ALU_ARB_FLAGS_EN
  assign rsp_carry = carry_q;
  assign rsp_zero  = zero_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_alu_arbiter: directed self-checking bench for alu_arbiter, with a |
// | round-robin instance and a fixed-priority instance on shared inputs. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, rsp_ready;
  logic [1:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;

  logic       req0_ready, req1_ready, rsp_valid, rsp_id;
  logic [7:0] rsp_data;
  logic       fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id;
  logic [7:0] fp_rsp_data;
`ifdef ALU_ARB_FLAGS_EN
  logic       rsp_carry, rsp_zero, fp_rsp_carry, fp_rsp_zero;
`endif

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id)
`ifdef ALU_ARB_FLAGS_EN
    , .rsp_carry(rsp_carry), .rsp_zero(rsp_zero)
`endif
  );

  alu_arbiter #(.FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(fp_rsp_data),
    .rsp_id(fp_rsp_id)
`ifdef ALU_ARB_FLAGS_EN
    , .rsp_carry(fp_rsp_carry), .rsp_zero(fp_rsp_zero)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
  endtask

  initial begin
    // Reset state; a valid request during reset must not be accepted.
    rst = 1'b1;
    rsp_ready = 1'b0;
    set0(1'b1, 2'b00, 8'h00, 8'h00);
    set1(1'b0, 2'b00, 8'h00, 8'h00);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_req0_ready", req0_ready, 0);
`ifdef ALU_ARB_FLAGS_EN
    check("rst_carry", rsp_carry, 0);
    check("rst_zero", rsp_zero, 0);
`endif
    tick();
    tick();
    rst = 1'b0;

    // Single add with wrap: F0 + 20 = 10, carry out.
    set0(1'b1, 2'b00, 8'hF0, 8'h20);
    rsp_ready = 1'b1;
    #1;
    check("a_req0_ready", req0_ready, 1);
    check("a_req1_ready", req1_ready, 0);
    check("a_rsp_valid_pre", rsp_valid, 0);
    tick();
    set0(1'b0, 2'b00, 8'h00, 8'h00);
    #1;
    check("a_rsp_valid", rsp_valid, 1);
    check("a_rsp_data", rsp_data, 8'h10);
    check("a_rsp_id", rsp_id, 0);
`ifdef ALU_ARB_FLAGS_EN
    check("a_carry", rsp_carry, 1);
    check("a_zero", rsp_zero, 0);
`endif

    // Fresh reset so the first tie goes to requester 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Round-robin: both valid, 01+02=03 from req0, 10-01=0F from req1.
    set0(1'b1, 2'b00, 8'h01, 8'h02);
    set1(1'b1, 2'b01, 8'h10, 8'h01);
    rsp_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("b_req0_ready", req0_ready, (i % 2 == 0));
      check("b_req1_ready", req1_ready, (i % 2 == 1));
      if (i > 0) begin
        check("b_rsp_valid", rsp_valid, 1);
        check("b_rsp_id", rsp_id, (i - 1) % 2);
        check("b_rsp_data", rsp_data, ((i - 1) % 2 == 0) ? 8'h03 : 8'h0F);
      end
      tick();
    end
    set0(1'b0, 2'b00, 8'h00, 8'h00);
    set1(1'b0, 2'b00, 8'h00, 8'h00);
    #1;
    check("b_last_valid", rsp_valid, 1);
    check("b_last_id", rsp_id, 1);
    check("b_last_data", rsp_data, 8'h0F);
    tick();
    check("b_drained", rsp_valid, 0);

    // Stall: 05-07 = FE with borrow, held while rsp_ready=0.
    set1(1'b1, 2'b01, 8'h05, 8'h07);
    rsp_ready = 1'b0;
    #1;
    check("c_req1_ready", req1_ready, 1);
    check("c_req0_ready", req0_ready, 0);
    tick();
    set0(1'b1, 2'b00, 8'h01, 8'h01);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("c_stall_valid", rsp_valid, 1);
      check("c_stall_data", rsp_data, 8'hFE);
      check("c_stall_id", rsp_id, 1);
      check("c_stall_req0_ready", req0_ready, 0);
      check("c_stall_req1_ready", req1_ready, 0);
`ifdef ALU_ARB_FLAGS_EN
      check("c_stall_carry", rsp_carry, 1);
`endif
      tick();
    end
    rsp_ready = 1'b1;
    set0(1'b0, 2'b00, 8'h00, 8'h00);
    set1(1'b0, 2'b00, 8'h00, 8'h00);
    #1;
    check("c_before_drain", rsp_valid, 1);
    tick();
    check("c_after_drain", rsp_valid, 0);

    // Bitwise: 0F & F0 = 00, then back-to-back 0F | F0 = FF.
    set0(1'b1, 2'b10, 8'h0F, 8'hF0);
    #1;
    check("d_and_ready", req0_ready, 1);
    tick();
    check("d_and_data", rsp_data, 8'h00);
    check("d_and_valid", rsp_valid, 1);
`ifdef ALU_ARB_FLAGS_EN
    check("d_and_zero", rsp_zero, 1);
    check("d_and_carry", rsp_carry, 0);
`endif
    set0(1'b1, 2'b11, 8'h0F, 8'hF0);
    #1;
    check("d_or_ready", req0_ready, 1);
    tick();
    check("d_or_data", rsp_data, 8'hFF);
    check("d_or_id", rsp_id, 0);
`ifdef ALU_ARB_FLAGS_EN
    check("d_or_zero", rsp_zero, 0);
`endif
    set0(1'b0, 2'b00, 8'h00, 8'h00);
    tick();
    check("d_drained", rsp_valid, 0);

    // Reset while FULL discards the result immediately.
    set0(1'b1, 2'b00, 8'h11, 8'h22);
    rsp_ready = 1'b0;
    #1;
    tick();
    check("e_full_valid", rsp_valid, 1);
    check("e_full_data", rsp_data, 8'h33);
    rst = 1'b1;
    #1;
    check("e_rst_valid", rsp_valid, 0);
    check("e_rst_data", rsp_data, 8'h00);
    check("e_rst_id", rsp_id, 0);
    check("e_rst_req0_ready", req0_ready, 0);
    tick();
    rst = 1'b0;
    set1(1'b1, 2'b00, 8'h01, 8'h01);
    rsp_ready = 1'b1;
    #1;
    check("e_tie_req0_ready", req0_ready, 1);
    check("e_tie_req1_ready", req1_ready, 0);
    tick();

    // Fixed priority: requester 0 always wins with both valid.
    for (int i = 0; i < 4; i++) begin
      check("f_fp_req0_ready", fp_req0_ready, 1);
      check("f_fp_req1_ready", fp_req1_ready, 0);
      check("f_fp_rsp_id", fp_rsp_id, 0);
      tick();
    end

    set0(1'b0, 2'b00, 8'h00, 8'h00);
    set1(1'b0, 2'b00, 8'h00, 8'h00);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
